// File: rtl/craps_pkg.sv
// Shared definitions for the craps roll controller and its scoring helpers:
// state encodings, dice/sum constants and small die-conditioning functions.
package craps_pkg;

    typedef logic [2:0] die_t;
    typedef logic [3:0] sum_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_EVAL   = 3'd2;
    localparam logic [2:0] ST_POINT  = 3'd3;
    localparam logic [2:0] ST_WIN    = 3'd4;
    localparam logic [2:0] ST_LOSE   = 3'd5;

    localparam sum_t SUM_SEVEN   = 4'd7;
    localparam sum_t SUM_ELEVEN  = 4'd11;
    localparam sum_t SUM_CRAPS2  = 4'd2;
    localparam sum_t SUM_CRAPS3  = 4'd3;
    localparam sum_t SUM_CRAPS12 = 4'd12;

    localparam die_t DIE_MIN = 3'd1;
    localparam die_t DIE_MAX = 3'd6;

    function automatic logic die_valid(input die_t d);
        return (d >= DIE_MIN) && (d <= DIE_MAX);
    endfunction

    // Out-of-range faces snap to the nearest legal face; legal faces pass through.
    function automatic die_t die_clamp(input die_t d);
        die_t r;
        if (d < DIE_MIN) begin
            r = DIE_MIN;
        end else if (d > DIE_MAX) begin
            r = DIE_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic sum_t die_sum(input die_t a, input die_t b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/craps_eval.sv
// Pure combinational craps rule decode: given a dice sum and the current point,
// says whether the roll wins, loses or establishes a new point.
module craps_eval
    import craps_pkg::*;
(
    input  logic [3:0] sum,
    input  logic [3:0] point,
    input  logic       point_valid,
    output logic       is_win,
    output logic       is_lose,
    output logic       set_point
);

    logic natural_s;
    logic craps_s;
    logic match_s;
    logic seven_s;

    assign natural_s = (sum == SUM_SEVEN) || (sum == SUM_ELEVEN);
    assign craps_s   = (sum == SUM_CRAPS2) || (sum == SUM_CRAPS3) || (sum == SUM_CRAPS12);
    assign match_s   = (sum == point);
    assign seven_s   = (sum == SUM_SEVEN);

    // Point match takes precedence over seven-out in the point phase.
    always_comb begin
        is_win    = 1'b0;
        is_lose   = 1'b0;
        set_point = 1'b0;
        if (point_valid) begin
            if (match_s) begin
                is_win = 1'b1;
            end else if (seven_s) begin
                is_lose = 1'b1;
            end else begin
                is_win = 1'b0;
            end
        end else begin
            if (natural_s) begin
                is_win = 1'b1;
            end else if (craps_s) begin
                is_lose = 1'b1;
            end else begin
                set_point = 1'b1;
            end
        end
    end

endmodule

// File: rtl/craps_roll_ctrl.sv
// Craps game sequencer: samples the two-die source on a roll edge, retries or
// clamps illegal faces, then applies come-out/point rules and holds the result.
module craps_roll_ctrl
    import craps_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll,
    input  logic [2:0]       dice1_in,
    input  logic [2:0]       dice2_in,
    output logic [2:0]       die1_out,
    output logic [2:0]       die2_out,
    output logic [3:0]       sum_out,
    output logic [3:0]       point_out,
    output logic             point_valid,
    output logic             win,
    output logic             lose,
    output logic             busy,
    output logic             roll_done,
    output logic [CNT_W-1:0] roll_count
);

    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [2:0]       state_q,      state_d;
    logic [3:0]       retry_cnt_q,  retry_cnt_d;
    logic             roll_q;
    die_t             die1_q,       die1_d;
    die_t             die2_q,       die2_d;
    sum_t             sum_q,        sum_d;
    sum_t             point_q,      point_d;
    logic             point_valid_q, point_valid_d;
    logic             win_q,        win_d;
    logic             lose_q,       lose_d;
    logic             busy_q,       busy_d;
    logic             roll_done_q,  roll_done_d;
    logic [CNT_W-1:0] roll_count_q, roll_count_d;

    logic roll_edge_s;
    logic sample_ok_s;
    sum_t eval_sum_s;
    logic is_win_s;
    logic is_lose_s;
    logic set_point_s;

    assign roll_edge_s = roll & ~roll_q;
    assign sample_ok_s = die_valid(dice1_in) && die_valid(dice2_in);
    assign eval_sum_s  = die_sum(die1_q, die2_q);

    craps_eval u_eval (
        .sum         (eval_sum_s),
        .point       (point_q),
        .point_valid (point_valid_q),
        .is_win      (is_win_s),
        .is_lose     (is_lose_s),
        .set_point   (set_point_s)
    );

    // Next-state and result update for the game sequencer.
    always_comb begin
        state_d       = state_q;
        retry_cnt_d   = retry_cnt_q;
        die1_d        = die1_q;
        die2_d        = die2_q;
        sum_d         = sum_q;
        point_d       = point_q;
        point_valid_d = point_valid_q;
        win_d         = win_q;
        lose_d        = lose_q;
        roll_done_d   = 1'b0;
        roll_count_d  = roll_count_q;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (roll_edge_s) begin
                    state_d       = ST_SAMPLE;
                    retry_cnt_d   = 4'd0;
                    point_d       = 4'd0;
                    point_valid_d = 1'b0;
                    win_d         = 1'b0;
                    lose_d        = 1'b0;
                    roll_count_d  = CNT_ONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_POINT: begin
                if (roll_edge_s) begin
                    state_d     = ST_SAMPLE;
                    retry_cnt_d = 4'd0;
                    if (roll_count_q != CNT_MAX) begin
                        roll_count_d = roll_count_q + CNT_ONE;
                    end else begin
                        roll_count_d = roll_count_q;
                    end
                end else begin
                    state_d = ST_POINT;
                end
            end
            ST_SAMPLE: begin
                if (sample_ok_s) begin
                    die1_d      = dice1_in;
                    die2_d      = dice2_in;
                    retry_cnt_d = 4'd0;
                    state_d     = ST_EVAL;
                end else if (retry_cnt_q < RETRY_LAST) begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    state_d     = ST_SAMPLE;
                end else begin
                    die1_d      = die_clamp(dice1_in);
                    die2_d      = die_clamp(dice2_in);
                    retry_cnt_d = 4'd0;
                    state_d     = ST_EVAL;
                end
            end
            ST_EVAL: begin
                sum_d       = eval_sum_s;
                roll_done_d = 1'b1;
                if (is_win_s) begin
                    win_d         = 1'b1;
                    point_valid_d = 1'b0;
                    state_d       = ST_WIN;
                end else if (is_lose_s) begin
                    lose_d        = 1'b1;
                    point_valid_d = 1'b0;
                    state_d       = ST_LOSE;
                end else if (set_point_s) begin
                    point_d       = eval_sum_s;
                    point_valid_d = 1'b1;
                    state_d       = ST_POINT;
                end else begin
                    state_d = ST_POINT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SAMPLE) || (state_d == ST_EVAL);
    end

    // State and result registers; roll_q resets high so a held button never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            retry_cnt_q   <= 4'd0;
            roll_q        <= 1'b1;
            die1_q        <= 3'd0;
            die2_q        <= 3'd0;
            sum_q         <= 4'd0;
            point_q       <= 4'd0;
            point_valid_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            busy_q        <= 1'b0;
            roll_done_q   <= 1'b0;
            roll_count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            retry_cnt_q   <= retry_cnt_d;
            roll_q        <= roll;
            die1_q        <= die1_d;
            die2_q        <= die2_d;
            sum_q         <= sum_d;
            point_q       <= point_d;
            point_valid_q <= point_valid_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            busy_q        <= busy_d;
            roll_done_q   <= roll_done_d;
            roll_count_q  <= roll_count_d;
        end
    end

    assign die1_out    = die1_q;
    assign die2_out    = die2_q;
    assign sum_out     = sum_q;
    assign point_out   = point_q;
    assign point_valid = point_valid_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign busy        = busy_q;
    assign roll_done   = roll_done_q;
    assign roll_count  = roll_count_q;

endmodule

// File: tb/tb_craps_roll_ctrl.sv
// Directed bench for craps_roll_ctrl: come-out, craps, point, seven-out,
// retry/clamp timing, ignored edges and reset behaviour.
module tb_craps_roll_ctrl;

    logic       clk;
    logic       rst;
    logic       roll;
    logic [2:0] dice1_in;
    logic [2:0] dice2_in;
    logic [2:0] die1_out;
    logic [2:0] die2_out;
    logic [3:0] sum_out;
    logic [3:0] point_out;
    logic       point_valid;
    logic       win;
    logic       lose;
    logic       busy;
    logic       roll_done;
    logic [7:0] roll_count;

    int tests_run    = 0;
    int tests_failed = 0;

    craps_roll_ctrl #(.MAX_RETRY(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .roll        (roll),
        .dice1_in    (dice1_in),
        .dice2_in    (dice2_in),
        .die1_out    (die1_out),
        .die2_out    (die2_out),
        .sum_out     (sum_out),
        .point_out   (point_out),
        .point_valid (point_valid),
        .win         (win),
        .lose        (lose),
        .busy        (busy),
        .roll_done   (roll_done),
        .roll_count  (roll_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full roll with legal dice: returns 1 time unit after E2 (results visible).
    task automatic play(input logic [2:0] d1, input logic [2:0] d2);
        roll = 1'b0;
        step();
        dice1_in = d1;
        dice2_in = d2;
        roll = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic check_result(input string tag, input logic [3:0] s, input logic w,
                                input logic l, input logic pv, input logic [3:0] pt,
                                input logic [7:0] cnt);
        check_val({tag, "_sum"},   32'(sum_out),     32'(s));
        check_val({tag, "_win"},   32'(win),         32'(w));
        check_val({tag, "_lose"},  32'(lose),        32'(l));
        check_val({tag, "_pv"},    32'(point_valid), 32'(pv));
        check_val({tag, "_point"}, 32'(point_out),   32'(pt));
        check_val({tag, "_cnt"},   32'(roll_count),  32'(cnt));
        check_val({tag, "_done"},  32'(roll_done),   32'd1);
        check_val({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    initial begin
        rst = 1'b1;
        roll = 1'b0;
        dice1_in = 3'd1;
        dice2_in = 3'd1;
        step();
        step();
        rst = 1'b0;
        step();
        check_val("rst_sum",  32'(sum_out),    32'd0);
        check_val("rst_die1", 32'(die1_out),   32'd0);
        check_val("rst_busy", 32'(busy),       32'd0);
        check_val("rst_cnt",  32'(roll_count), 32'd0);
        check_val("rst_win",  32'(win),        32'd0);

        // Come-out natural 7 with detailed latency checks.
        dice1_in = 3'd3;
        dice2_in = 3'd4;
        roll = 1'b1;
        step();
        check_val("co7_e0_busy", 32'(busy),       32'd1);
        check_val("co7_e0_cnt",  32'(roll_count), 32'd1);
        step();
        check_val("co7_e1_die1", 32'(die1_out),  32'd3);
        check_val("co7_e1_die2", 32'(die2_out),  32'd4);
        check_val("co7_e1_done", 32'(roll_done), 32'd0);
        check_val("co7_e1_busy", 32'(busy),      32'd1);
        step();
        check_result("co7", 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
        step();
        check_val("co7_e3_done", 32'(roll_done), 32'd0);

        // Craps 2, then a new game clears lose at E0 and 5,6 wins.
        play(3'd1, 3'd1);
        check_result("craps2", 4'd2, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);
        roll = 1'b0;
        step();
        dice1_in = 3'd5;
        dice2_in = 3'd6;
        roll = 1'b1;
        step();
        check_val("new_game_lose_clr", 32'(lose), 32'd0);
        step();
        step();
        check_result("co11", 4'd11, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);

        // Point 4 established, 6 is no decision, 4 makes the point.
        play(3'd2, 3'd2);
        check_result("pt4", 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd1);
        play(3'd3, 3'd3);
        check_result("pt4_6", 4'd6, 1'b0, 1'b0, 1'b1, 4'd4, 8'd2);
        play(3'd1, 3'd3);
        check_result("pt4_made", 4'd4, 1'b1, 1'b0, 1'b0, 4'd4, 8'd3);

        // Seven-out on point 6; point_out holds until the next game starts.
        play(3'd3, 3'd3);
        check_result("pt6", 4'd6, 1'b0, 1'b0, 1'b1, 4'd6, 8'd1);
        play(3'd3, 3'd4);
        check_result("seven_out", 4'd7, 1'b0, 1'b1, 1'b0, 4'd6, 8'd2);

        // Clamp: (0,7) held for all four tries -> 1,6 = 7, roll_done at E5.
        roll = 1'b0;
        step();
        dice1_in = 3'd0;
        dice2_in = 3'd7;
        roll = 1'b1;
        step();
        check_val("clamp_e0_point_clr", 32'(point_out), 32'd0);
        check_val("clamp_e0_lose_clr",  32'(lose),      32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("clamp_retry_busy", 32'(busy),      32'd1);
            check_val("clamp_retry_done", 32'(roll_done), 32'd0);
        end
        step();
        check_val("clamp_e4_die1", 32'(die1_out),  32'd1);
        check_val("clamp_e4_die2", 32'(die2_out),  32'd6);
        check_val("clamp_e4_done", 32'(roll_done), 32'd0);
        step();
        check_result("clamp", 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);

        // Two invalid samples then 5,6 -> 11 at E4.
        roll = 1'b0;
        step();
        dice1_in = 3'd7;
        dice2_in = 3'd3;
        roll = 1'b1;
        step();
        step();
        step();
        dice1_in = 3'd5;
        dice2_in = 3'd6;
        step();
        check_val("retry2_e3_done", 32'(roll_done), 32'd0);
        check_val("retry2_e3_die1", 32'(die1_out),  32'd5);
        step();
        check_result("retry2", 4'd11, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);

        // Second edge arrives while in EVAL and must be dropped.
        roll = 1'b0;
        step();
        dice1_in = 3'd2;
        dice2_in = 3'd2;
        roll = 1'b1;
        step();
        roll = 1'b0;
        step();
        roll = 1'b1;
        step();
        check_result("busy_edge", 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd1);
        step();
        step();
        check_val("busy_edge_idle", 32'(busy),       32'd0);
        check_val("busy_edge_cnt",  32'(roll_count), 32'd1);

        // Reset while stuck in SAMPLE clears everything at that edge.
        roll = 1'b0;
        step();
        dice1_in = 3'd0;
        dice2_in = 3'd0;
        roll = 1'b1;
        step();
        step();
        check_val("srst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check_val("srst_busy",  32'(busy),        32'd0);
        check_val("srst_point", 32'(point_out),   32'd0);
        check_val("srst_pv",    32'(point_valid), 32'd0);
        check_val("srst_sum",   32'(sum_out),     32'd0);
        check_val("srst_die1",  32'(die1_out),    32'd0);
        check_val("srst_cnt",   32'(roll_count),  32'd0);

        // Roll held high through reset release must not start a game.
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("held_roll_busy", 32'(busy),       32'd0);
            check_val("held_roll_cnt",  32'(roll_count), 32'd0);
        end

        // From IDLE after reset, a fresh edge starts a game (come-out 8 -> point).
        play(3'd4, 3'd4);
        check_result("post_rst", 4'd8, 1'b0, 1'b0, 1'b1, 4'd8, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
